// File: rtl/util_gmii_frame_monitor.sv
// Passive GMII frame monitor: delimits frames on tx_en, checks preamble/SFD, length and errors, keeps stats.
// Latency: the frame report is registered and is visible the cycle after the edge that samples tx_en=0.
// Backpressure: none; this is a pure tap, it never stalls or drives the GMII bus.
module util_gmii_frame_monitor #(
   parameter int CNT_WIDTH    = 32,
   parameter int MIN_PREAMBLE = 1,
   parameter int MIN_LEN      = 64,
   parameter int MAX_LEN      = 1522
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           gmii_txd,
   input  logic                 gmii_tx_er,
   input  logic                 gmii_tx_en,
   input  logic                 clear,
   output logic                 frame_valid,
   output logic [15:0]          frame_length,
   output logic                 frame_good,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] bad_count,
   output logic [CNT_WIDTH-1:0] byte_count
);

   // Sum width wide enough that the byte accumulator add cannot overflow before the saturation test.
   localparam int SW = ((CNT_WIDTH > 16) ? CNT_WIDTH : 16) + 1;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
   localparam logic [15:0]          MIN_LEN_W   = 16'(MIN_LEN);
   localparam logic [15:0]          MAX_LEN_W   = 16'(MAX_LEN);
   localparam logic [2:0]           MIN_PRE_W   = 3'(MIN_PREAMBLE);
   localparam logic [7:0]           PRE_BYTE    = 8'h55;
   localparam logic [7:0]           SFD_BYTE    = 8'hD5;

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            len_q, len_d;
   logic [2:0]             pre_cnt_q, pre_cnt_d;
   logic                   err_q, err_d;
   logic                   frame_valid_q, frame_valid_d;
   logic [15:0]            frame_length_q, frame_length_d;
   logic                   frame_good_q, frame_good_d;
   logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
   logic [CNT_WIDTH-1:0]   bad_count_q, bad_count_d;
   logic [CNT_WIDTH-1:0]   byte_count_q, byte_count_d;

   logic                   report;
   logic [15:0]            rpt_len;
   logic                   rpt_good;
   logic [SW-1:0]          byte_sum;

   // Frame delimiting FSM: tracks preamble, SFD, payload length and accumulated error.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      pre_cnt_d = pre_cnt_q;
      err_d     = err_q;
      report    = 1'b0;
      rpt_len   = 16'd0;
      rpt_good  = 1'b0;

      case (state_q)
         SYNC: begin
            // Wait for a gap so a frame already in flight at reset release is never reported.
            if (!gmii_tx_en) state_d = IDLE;
         end
         IDLE: begin
            if (gmii_tx_en) begin
               if (gmii_txd == PRE_BYTE) begin
                  state_d   = PREAMBLE;
                  pre_cnt_d = 3'd1;
               end else begin
                  state_d = DROP;
                  err_d   = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (gmii_tx_en) begin
               if (gmii_txd == PRE_BYTE) begin
                  pre_cnt_d = (pre_cnt_q == 3'd7) ? pre_cnt_q : pre_cnt_q + 3'd1;
                  err_d     = err_q | gmii_tx_er;
               end else if (gmii_txd == SFD_BYTE) begin
                  state_d = DATA;
                  len_d   = 16'd0;
                  err_d   = err_q | gmii_tx_er | (pre_cnt_q < MIN_PRE_W);
               end else begin
                  state_d = DROP;
                  err_d   = 1'b1;
               end
            end else begin
               // Carrier dropped before the SFD: report a zero-length bad frame.
               report  = 1'b1;
               state_d = IDLE;
            end
         end
         DATA: begin
            if (gmii_tx_en) begin
               len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
               err_d = err_q | gmii_tx_er;
            end else begin
               report   = 1'b1;
               rpt_len  = len_q;
               rpt_good = !err_q && (len_q >= MIN_LEN_W) && (len_q <= MAX_LEN_W);
               state_d  = IDLE;
            end
         end
         DROP: begin
            if (!gmii_tx_en) begin
               report  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = SYNC;
      endcase

      if (report) begin
         err_d     = 1'b0;
         pre_cnt_d = 3'd0;
      end
   end

   // Report outputs and saturating statistics counters; clear overrides a coincident report.
   always_comb begin
      frame_valid_d  = report;
      frame_length_d = report ? rpt_len  : frame_length_q;
      frame_good_d   = report ? rpt_good : frame_good_q;
      frame_count_d  = frame_count_q;
      bad_count_d    = bad_count_q;
      byte_count_d   = byte_count_q;
      byte_sum       = SW'(byte_count_q) + SW'(rpt_len);

      if (clear) begin
         frame_count_d = '0;
         bad_count_d   = '0;
         byte_count_d  = '0;
      end else if (report) begin
         frame_count_d = (frame_count_q == CNT_MAX) ? frame_count_q : frame_count_q + 1'b1;
         if (!rpt_good) begin
            bad_count_d = (bad_count_q == CNT_MAX) ? bad_count_q : bad_count_q + 1'b1;
         end else if (byte_sum > SW'(CNT_MAX)) begin
            byte_count_d = CNT_MAX;
         end else begin
            byte_count_d = byte_sum[CNT_WIDTH-1:0];
         end
      end
   end

   // State and registered outputs; reset drops any partial frame without a report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= SYNC;
         len_q          <= 16'd0;
         pre_cnt_q      <= 3'd0;
         err_q          <= 1'b0;
         frame_valid_q  <= 1'b0;
         frame_length_q <= 16'd0;
         frame_good_q   <= 1'b0;
         frame_count_q  <= '0;
         bad_count_q    <= '0;
         byte_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         pre_cnt_q      <= pre_cnt_d;
         err_q          <= err_d;
         frame_valid_q  <= frame_valid_d;
         frame_length_q <= frame_length_d;
         frame_good_q   <= frame_good_d;
         frame_count_q  <= frame_count_d;
         bad_count_q    <= bad_count_d;
         byte_count_q   <= byte_count_d;
      end
   end

   assign frame_valid  = frame_valid_q;
   assign frame_length = frame_length_q;
   assign frame_good   = frame_good_q;
   assign frame_count  = frame_count_q;
   assign bad_count    = bad_count_q;
   assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_util_gmii_frame_monitor.sv
// Directed bench for util_gmii_frame_monitor: frames driven byte by byte, reports checked against hand values.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge before inputs change.
// Backpressure: not applicable, the monitor is passive.
module tb_util_gmii_frame_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_er;
   logic        gmii_tx_en;
   logic        clear;

   logic        frame_valid, frame_good;
   logic [15:0] frame_length;
   logic [31:0] frame_count, bad_count, byte_count;

   logic        d2_frame_valid, d2_frame_good;
   logic [15:0] d2_frame_length;
   logic [31:0] d2_frame_count, d2_bad_count, d2_byte_count;

   int vectors    = 0;
   int miscompares = 0;
   int pulses     = 0;
   int p0;

   util_gmii_frame_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gmii_txd     (gmii_txd),
      .gmii_tx_er   (gmii_tx_er),
      .gmii_tx_en   (gmii_tx_en),
      .clear        (clear),
      .frame_valid  (frame_valid),
      .frame_length (frame_length),
      .frame_good   (frame_good),
      .frame_count  (frame_count),
      .bad_count    (bad_count),
      .byte_count   (byte_count)
   );

   // Second instance with a stricter preamble requirement, fed the same stream.
   util_gmii_frame_monitor #(.MIN_PREAMBLE(2)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .gmii_txd     (gmii_txd),
      .gmii_tx_er   (gmii_tx_er),
      .gmii_tx_en   (gmii_tx_en),
      .clear        (clear),
      .frame_valid  (d2_frame_valid),
      .frame_length (d2_frame_length),
      .frame_good   (d2_frame_good),
      .frame_count  (d2_frame_count),
      .bad_count    (d2_bad_count),
      .byte_count   (d2_byte_count)
   );

   always #4 clk = ~clk;

   // Count report pulses; sampled on the rising edge, so it sees the value held during the previous cycle.
   always @(posedge clk) begin
      if (frame_valid === 1'b1) pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic put(input logic en, input logic er, input logic [7:0] d);
      @(negedge clk);
      gmii_tx_en = en;
      gmii_tx_er = er;
      gmii_txd   = d;
   endtask

   task automatic send_frame(input int npre, input int nlen, input int er_at, input bit term);
      for (int i = 0; i < npre; i++) put(1'b1, 1'b0, 8'h55);
      put(1'b1, 1'b0, 8'hD5);
      for (int i = 1; i <= nlen; i++) put(1'b1, (i == er_at), 8'(i));
      if (term) put(1'b0, 1'b0, 8'h00);
   endtask

   // Expects the pulse in the cycle after tx_en=0 was sampled, and gone the cycle after.
   task automatic check_report(input string tag, input int len, input bit good,
                               input int fc, input int bc, input int byc);
      @(negedge clk);
      chk({tag, "_vld"},  frame_valid,  1);
      chk({tag, "_len"},  frame_length, len);
      chk({tag, "_good"}, frame_good,   good);
      chk({tag, "_fc"},   frame_count,  fc);
      chk({tag, "_bc"},   bad_count,    bc);
      chk({tag, "_byc"},  byte_count,   byc);
      @(negedge clk);
      chk({tag, "_vld_off"}, frame_valid, 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_vld"},  frame_valid,  0);
      chk({tag, "_len"},  frame_length, 0);
      chk({tag, "_good"}, frame_good,   0);
      chk({tag, "_fc"},   frame_count,  0);
      chk({tag, "_bc"},   bad_count,    0);
      chk({tag, "_byc"},  byte_count,   0);
   endtask

   initial begin
      rst_n      = 1'b0;
      gmii_txd   = 8'h00;
      gmii_tx_er = 1'b0;
      gmii_tx_en = 1'b0;
      clear      = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Minimum-size good frame with full preamble.
      send_frame(7, 64, 0, 1'b1);
      check_report("good64", 64, 1'b1, 1, 0, 64);

      // tx_er on payload byte 50.
      send_frame(7, 100, 50, 1'b1);
      check_report("txer", 100, 1'b0, 2, 1, 64);

      // Runt, oversize, and maximum size.
      send_frame(7, 63, 0, 1'b1);
      check_report("runt63", 63, 1'b0, 3, 2, 64);
      send_frame(7, 1523, 0, 1'b1);
      check_report("big1523", 1523, 1'b0, 4, 3, 64);
      send_frame(7, 1522, 0, 1'b1);
      check_report("max1522", 1522, 1'b1, 5, 3, 1586);

      // Corrupt preamble: 0x55 0x55 0x12 then filler, 20 bytes total.
      put(1'b1, 1'b0, 8'h55);
      put(1'b1, 1'b0, 8'h55);
      put(1'b1, 1'b0, 8'h12);
      for (int i = 0; i < 17; i++) put(1'b1, 1'b0, 8'hAA);
      put(1'b0, 1'b0, 8'h00);
      check_report("badpre", 0, 1'b0, 6, 4, 1586);

      // Carrier lost during preamble.
      for (int i = 0; i < 3; i++) put(1'b1, 1'b0, 8'h55);
      put(1'b0, 1'b0, 8'h00);
      check_report("predrop", 0, 1'b0, 7, 5, 1586);

      // Single preamble byte: good for MIN_PREAMBLE=1, bad for MIN_PREAMBLE=2.
      send_frame(1, 64, 0, 1'b1);
      check_report("pre1", 64, 1'b1, 8, 5, 1650);
      chk("pre1_d2_good", d2_frame_good,   0);
      chk("pre1_d2_len",  d2_frame_length, 64);

      // Counter clear on its own.
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      chk("clr_fc",  frame_count, 0);
      chk("clr_bc",  bad_count,   0);
      chk("clr_byc", byte_count,  0);

      // Back-to-back frames with a single idle cycle.
      p0 = pulses;
      send_frame(7, 64, 0, 1'b1);
      send_frame(7, 64, 0, 1'b1);
      check_report("b2b", 64, 1'b1, 2, 0, 128);
      chk("b2b_pulses", pulses - p0, 2);

      // Clear coincident with a report: report still shown, counters zeroed.
      send_frame(7, 64, 0, 1'b0);
      @(negedge clk);
      gmii_tx_en = 1'b0;
      clear      = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clrrpt_vld",  frame_valid,  1);
      chk("clrrpt_len",  frame_length, 64);
      chk("clrrpt_good", frame_good,   1);
      chk("clrrpt_fc",   frame_count,  0);
      chk("clrrpt_bc",   bad_count,    0);
      chk("clrrpt_byc",  byte_count,   0);

      // Load nonzero state, then reset mid-payload.
      send_frame(7, 64, 0, 1'b1);
      check_report("prerst", 64, 1'b1, 1, 0, 64);
      send_frame(7, 10, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      p0 = pulses;
      put(1'b1, 1'b0, 8'h33);
      put(1'b1, 1'b0, 8'h34);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) put(1'b1, 1'b0, 8'h77);
      put(1'b0, 1'b0, 8'h00);
      repeat (4) @(negedge clk);
      chk("rstrel_pulses", pulses - p0, 0);
      chk("rstrel_fc", frame_count, 0);

      // First clean frame after reset.
      send_frame(7, 64, 0, 1'b1);
      check_report("postrst", 64, 1'b1, 1, 0, 64);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
